// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives program_memory, assembles 1/2-byte instructions for decode.
// Optional self-loop BRA halt under `define FETCH_SELF_LOOP_HALT_EN.
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC   = 8'd0,
  parameter int unsigned BOOT_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pm_addr,
  input  logic [7:0] pm_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_op,
  output logic [7:0] instr_imm,
  output logic       instr_len2,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH1,
    S_FETCH2,
    S_HOLD
`ifdef FETCH_SELF_LOOP_HALT_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

  state_t     r_state;
  logic [3:0] r_boot_cnt;
  logic [7:0] r_pc;
  logic       r_valid;
  logic [7:0] r_op;
  logic [7:0] r_imm;
  logic       r_len2;
  logic [7:0] r_ipc;

  logic       w_two;
  logic [7:0] w_pc_inc;

  assign w_two    = (pm_data[7:4] == 4'b1000) ||
                    (pm_data[7:5] == 3'b101);
  assign w_pc_inc = r_pc + 8'd1;

  assign pm_addr     = r_pc;
  assign instr_valid = r_valid;
  assign instr_op    = r_op;
  assign instr_imm   = r_imm;
  assign instr_len2  = r_len2;
  assign instr_pc    = r_ipc;

`ifdef FETCH_SELF_LOOP_HALT_EN
  logic r_halted;
  logic w_self_loop;

  assign w_self_loop = r_valid && instr_ready &&
                       (r_op == 8'hA8) &&
                       (r_imm == r_ipc);
  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= '0;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_op       <= '0;
      r_imm      <= '0;
      r_len2     <= 1'b0;
      r_ipc      <= '0;
`ifdef FETCH_SELF_LOOP_HALT_EN
      r_halted   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_BOOT: begin
          if (r_boot_cnt == BOOT_LAST)
            r_state <= S_FETCH1;
          else
            r_boot_cnt <= r_boot_cnt + 4'd1;
        end
        S_FETCH1: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else begin
            r_op   <= pm_data;
            r_ipc  <= r_pc;
            r_len2 <= w_two;
            r_pc   <= w_pc_inc;
            if (w_two) begin
              r_state <= S_FETCH2;
            end else begin
              r_imm   <= '0;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end
        end
        S_FETCH2: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_state <= S_FETCH1;
          end else begin
            r_imm   <= pm_data;
            r_pc    <= w_pc_inc;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid || instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH1;
          end
          if (redirect_valid)
            r_pc <= redirect_pc;
`ifdef FETCH_SELF_LOOP_HALT_EN
          // a completed self-loop wins over any redirect
          if (w_self_loop) begin
            r_pc     <= r_pc;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end
`endif
        end
`ifdef FETCH_SELF_LOOP_HALT_EN
        S_HALT: begin
          r_state <= S_HALT;
        end
`endif
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: scoreboard of accepted instructions plus cycle checks.
// Covers boot, backpressure, redirects, PC wrap and the self-loop halt option.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pm_addr, pm_data;
  logic       instr_valid, instr_ready;
  logic [7:0] instr_op, instr_imm, instr_pc;
  logic       instr_len2;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;

  logic [7:0] w_addr, w_data, w_op, w_imm, w_pc;
  logic       w_valid, w_len2, w_halted;
  logic       w_ready, w_redir;
  logic [7:0] w_redir_pc;

  logic [7:0] rom  [256];
  logic [7:0] romw [256];

  always #5 clk = ~clk;

  assign pm_data    = rom[pm_addr];
  assign w_data     = romw[w_addr];
  assign w_ready    = 1'b0;
  assign w_redir    = 1'b0;
  assign w_redir_pc = 8'd0;

  fetch_sequencer u_dut (
    .clk(clk), .reset(reset),
    .pm_addr(pm_addr), .pm_data(pm_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .instr_len2(instr_len2), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted)
  );

  fetch_sequencer #(.RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .reset(reset),
    .pm_addr(w_addr), .pm_data(w_data),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr_op(w_op), .instr_imm(w_imm),
    .instr_len2(w_len2), .instr_pc(w_pc),
    .redirect_valid(w_redir),
    .redirect_pc(w_redir_pc),
    .halted(w_halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] imm;
    logic       len2;
    logic [7:0] pc;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input logic [7:0] op, input logic [7:0] imm,
                      input logic len2, input logic [7:0] pc);
    exp_t e;
    e.op   = op;
    e.imm  = imm;
    e.len2 = len2;
    e.pc   = pc;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_op", instr_op, e.op);
        chk("sb_imm", instr_imm, e.imm);
        chk("sb_len2", instr_len2, e.len2);
        chk("sb_pc", instr_pc, e.pc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] pat;

  initial begin
    reset          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'd0;
    foreach (rom[i]) rom[i] = 8'h00;
    foreach (romw[i]) romw[i] = 8'h00;
    rom[0]  = 8'h81; rom[1]  = 8'h00;
    rom[2]  = 8'h02; rom[3]  = 8'h03;
    rom[4]  = 8'h98; rom[5]  = 8'h04;
    rom[6]  = 8'h8E; rom[7]  = 8'h0A;
    rom[8]  = 8'h06;
    rom[9]  = 8'hB4; rom[10] = 8'h0D;
    rom[11] = 8'h07; rom[12] = 8'h08;
    rom[13] = 8'hC6; rom[14] = 8'h01;
    rom[15] = 8'hA8; rom[16] = 8'h0F;
    romw[255] = 8'h81; romw[0] = 8'h05;

    repeat (3) cyc();
    chk("rst_addr", pm_addr, 8'h00);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_op", instr_op, 8'h00);
    chk("rst_imm", instr_imm, 8'h00);
    chk("rst_len2", instr_len2, 1'b0);
    chk("rst_pc", instr_pc, 8'h00);
    chk("rst_halt", halted, 1'b0);
    chk("rst_waddr", w_addr, 8'hFF);

    reset = 1'b1;
    chk("boot_addr", pm_addr, 8'h00);
    chk("boot_valid", instr_valid, 1'b0);
    cyc();
    chk("f1_valid", instr_valid, 1'b0);
    chk("f1_addr", pm_addr, 8'h00);
    cyc();
    chk("f2_valid", instr_valid, 1'b0);
    chk("f2_addr", pm_addr, 8'h01);
    cyc();
    chk("b_valid", instr_valid, 1'b1);
    chk("b_op", instr_op, 8'h81);
    chk("b_imm", instr_imm, 8'h00);
    chk("b_len2", instr_len2, 1'b1);
    chk("b_pc", instr_pc, 8'h00);
    chk("b_addr", pm_addr, 8'h02);
    chk("w_op", w_op, 8'h81);
    chk("w_imm", w_imm, 8'h05);
    chk("w_pc", w_pc, 8'hFF);
    chk("w_addr", w_addr, 8'h01);

    push(8'h81, 8'h00, 1'b1, 8'd0);
    push(8'h02, 8'h00, 1'b0, 8'd2);
    push(8'h03, 8'h00, 1'b0, 8'd3);
    instr_ready = 1'b1;
    pat = 10'b0101000000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("tput1", instr_valid, pat[9-i]);
    end
    instr_ready = 1'b0;

    cyc();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_op", instr_op, 8'h98);
      chk("bp_pc", instr_pc, 8'd4);
      chk("bp_addr", pm_addr, 8'd5);
    end
    push(8'h98, 8'h00, 1'b0, 8'd4);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("add_f1", instr_valid, 1'b0);
    cyc();
    chk("add_valid", instr_valid, 1'b1);
    chk("add_op", instr_op, 8'h04);
    chk("add_pc", instr_pc, 8'd5);
    chk("add_len2", instr_len2, 1'b0);

    push(8'h04, 8'h00, 1'b0, 8'd5);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("cmp_f1", instr_valid, 1'b0);
    cyc();
    chk("cmp_f2_addr", pm_addr, 8'd7);
    chk("cmp_f2_valid", instr_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'd4;
    cyc();
    redirect_valid = 1'b0;
    chk("mid_valid", instr_valid, 1'b0);
    chk("mid_addr", pm_addr, 8'd4);
    cyc();
    chk("mid_hold", instr_valid, 1'b1);
    chk("mid_op", instr_op, 8'h98);
    chk("mid_pc", instr_pc, 8'd4);

    push(8'h98, 8'h00, 1'b0, 8'd4);
    push(8'h04, 8'h00, 1'b0, 8'd5);
    push(8'h8E, 8'h0A, 1'b1, 8'd6);
    push(8'h06, 8'h00, 1'b0, 8'd8);
    instr_ready = 1'b1;
    pat = 10'b0100101001;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("tput2", instr_valid, pat[9-i]);
    end
    chk("beq_op", instr_op, 8'hB4);
    chk("beq_imm", instr_imm, 8'h0D);
    chk("beq_pc", instr_pc, 8'd9);
    chk("beq_addr", pm_addr, 8'd11);
    push(8'hB4, 8'h0D, 1'b1, 8'd9);
    redirect_valid = 1'b1;
    redirect_pc    = 8'd13;
    cyc();
    redirect_valid = 1'b0;
    chk("rh_valid", instr_valid, 1'b0);
    chk("rh_addr", pm_addr, 8'd13);
    push(8'hC6, 8'h00, 1'b0, 8'd13);
    push(8'h01, 8'h00, 1'b0, 8'd14);
    push(8'hA8, 8'h0F, 1'b1, 8'd15);
    cyc();
    chk("c6_valid", instr_valid, 1'b1);
    chk("c6_op", instr_op, 8'hC6);
    chk("c6_pc", instr_pc, 8'd13);
    chk("c6_len2", instr_len2, 1'b0);
    pat = 10'b0100100000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("tput3", instr_valid, pat[9-i]);
    end
    chk("bra_op", instr_op, 8'hA8);
    chk("bra_imm", instr_imm, 8'h0F);
    chk("bra_pc", instr_pc, 8'd15);
    chk("bra_addr", pm_addr, 8'h11);
    redirect_valid = 1'b1;
    redirect_pc    = 8'd15;

`ifdef FETCH_SELF_LOOP_HALT_EN
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("halt_flag", halted, 1'b1);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_addr", pm_addr, 8'h11);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
`else
    cyc();
    redirect_valid = 1'b0;
    chk("loop_valid", instr_valid, 1'b0);
    chk("loop_addr", pm_addr, 8'd15);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cyc();
      chk("loop_hold", instr_valid, 1'b1);
      chk("loop_op", instr_op, 8'hA8);
      chk("loop_pc", instr_pc, 8'd15);
      chk("loop_halt", halted, 1'b0);
      push(8'hA8, 8'h0F, 1'b1, 8'd15);
      redirect_valid = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      chk("loop_f1", instr_valid, 1'b0);
      chk("loop_f1_addr", pm_addr, 8'd15);
    end
    instr_ready = 1'b0;
    cyc();
`endif

    reset = 1'b0;
    cyc();
    chk("r2_valid", instr_valid, 1'b0);
    chk("r2_halt", halted, 1'b0);
    chk("r2_addr", pm_addr, 8'h00);
    chk("r2_op", instr_op, 8'h00);
    reset = 1'b1;
    repeat (3) cyc();
    chk("r2_hold", instr_valid, 1'b1);
    chk("r2_op81", instr_op, 8'h81);
    chk("r2_pc", instr_pc, 8'h00);

    chk("sb_drain", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
